star_hub_arbiter: RTL and testbench
===================================

Name: star_hub_arbiter

Overview:
- Per-output round-robin wormhole arbiter for the star hub router: NPORTS leaf-facing inputs compete for NPORTS hub output ports.
- Each output is locked to one input from head flit to tail flit and gated by a per-output credit counter that tracks the downstream leaf buffer.
- Drives the hub crossbar select lines and the per-input grant/pop strobes.
- Sits between the hub input FIFOs and the hub crossbar.

Parameters:
- NPORTS, 10, number of leaf ports (inputs = outputs).
- DSTW, 4, width of a destination/input index; must satisfy 2^DSTW >= NPORTS.
- CREDITS, 4, downstream buffer depth per output; reset value of each credit counter.
- CRW, 3, credit counter width; must hold CREDITS.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  NPORTS  input i holds a flit at its FIFO head.
- req_dst  input  NPORTS*DSTW  destination output of input i's head flit (slice i).
- req_tail  input  NPORTS  head flit of input i is the packet tail.
- credit_ret  input  NPORTS  downstream leaf of output o freed one slot.
- grant  output  NPORTS  input i's head flit transfers this cycle (FIFO pop).
- sel  output  NPORTS*DSTW  crossbar select: input index driving output o (slice o).
- sel_valid  output  NPORTS  output o carries a valid flit this cycle.
- dst_err  output  1  sticky flag: an out-of-range req_dst or a credit overflow was seen.

Behaviour:
- Reset (rst=0 at posedge): every output goes to IDLE with owner=0, rr_ptr=NPORTS-1 (input 0 has top priority first), credit=CREDITS, dst_err=0. Outputs grant, sel_valid and sel read 0 while rst is low.
- Per-output FSM, state IDLE:
  - Candidates are inputs i with req_valid[i]=1, req_dst[i]=o, and i not owned by another output.
  - Winner is the first candidate searching from rr_ptr+1 upward, wrapping modulo NPORTS.
  - If a winner exists and credit>0: next state LOCKED, owner=winner.
  - IDLE never asserts a grant. Latency from head request to first grant is 1 cycle.
- Per-output FSM, state LOCKED:
  - xfer = req_valid[owner] & (req_dst[owner]==o) & (credit>0).
  - xfer drives grant[owner]=1, sel_valid[o]=1 and sel[o]=owner, all combinational from registered state.
  - An xfer on a flit with req_tail[owner]=1 returns the FSM to IDLE next cycle and sets rr_ptr=owner.
  - Without xfer the lock is held and the output stalls.
- Lock exclusivity:
  - An input is owned by at most one output, so at most one grant bit is set per input.
  - In the same cycle, several outputs may grant different inputs.
- Back-to-back packets: after a tail the output spends one IDLE cycle before the next packet is granted (one bubble per packet).
- Credits:
  - On xfer and no credit_ret: credit -1.
  - On credit_ret and no xfer: credit +1.
  - On both in the same cycle: unchanged.
  - credit_ret with credit==CREDITS and no xfer: counter holds at CREDITS and dst_err is set.
  - credit==0 blocks both the IDLE lock and LOCKED transfers.
- Out-of-range destination: req_dst[i] >= NPORTS is never granted and sets dst_err. dst_err clears only on reset.
- Single-flit packet (head is also tail): LOCKED for exactly one xfer cycle.
- Reset mid-packet: all locks drop and credits restore to CREDITS. Upstream flush is outside this block.

Test Plan:
- Round robin: after reset, inputs 0, 3 and 7 each send a single-flit packet to output 5 and hold valid. grant order is 0, 3, 7. Each grant lasts 1 cycle, separated by 1 IDLE cycle. sel[5] reads 0, 3, 7.
- Wormhole lock: input 2 sends a 3-flit packet to output 1 while input 4 also requests output 1. grant[2] is high for 3 consecutive cycles, then grant[4] follows after 1 bubble. grant[4] is never high during input 2's packet.
- Credit stall: CREDITS=4, a 6-flit packet from input 0 to output 9, no credit_ret. 4 grants, then a stall with sel_valid[9]=0. Pulsing credit_ret[9] twice yields 2 more grants, the last a tail, then the FSM returns to IDLE.
- Simultaneous credit: at credit=2, xfer and credit_ret[3] in the same cycle keep credit at 2. A credit_ret at credit=4 with no xfer keeps 4 and sets dst_err=1.
- Parallel outputs plus bad destination: inputs 1→2, 5→6 and 8→0 all granted in the same cycle. Input 9 with req_dst=12 is never granted and sets dst_err=1.
- Reset mid-packet: rst=0 during flit 2 of 4. The following cycle grant=0 and sel_valid=0. After rst=1, the next request to that output is granted with input 0 at top priority and credit back at 4.

Source files
------------

// File: rtl/star_hub_arbiter.sv
// Star hub output arbiter: per-output round-robin wormhole locking with
// credit gating, driving the crossbar selects and the input FIFO pops.
module star_hub_arbiter #(
   parameter int NPORTS  = 10,
   parameter int DSTW    = 4,
   parameter int CREDITS = 4,
   parameter int CRW     = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NPORTS-1:0]      req_valid,
   input  logic [NPORTS*DSTW-1:0] req_dst,
   input  logic [NPORTS-1:0]      req_tail,
   input  logic [NPORTS-1:0]      credit_ret,
   output logic [NPORTS-1:0]      grant,
   output logic [NPORTS*DSTW-1:0] sel,
   output logic [NPORTS-1:0]      sel_valid,
   output logic                   dst_err
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state_r  [NPORTS];
   logic [DSTW-1:0]   owner_r  [NPORTS];
   logic [DSTW-1:0]   rr_ptr_r [NPORTS];
   logic [CRW-1:0]    credit_r [NPORTS];
   logic              dst_err_r;

   logic [DSTW-1:0]   dst_s    [NPORTS];
   logic [NPORTS-1:0] owned_s;
   logic [NPORTS-1:0] xfer_s;
   logic [NPORTS-1:0] found_s;
   logic [DSTW-1:0]   winner_s [NPORTS];
   logic [DSTW-1:0]   scan_s;
   logic              bad_dst_s;
   logic              overflow_s;

   // Index reached by stepping 'step' places past 'base', wrapping at NPORTS.
   function automatic logic [DSTW-1:0] rr_index(input logic [DSTW-1:0] base, input int step);
      int sum;
      sum = (int'(base) + step) % NPORTS;
      return DSTW'(sum);
   endfunction

   genvar g;
   for (g = 0; g < NPORTS; g++) begin : g_dst
      assign dst_s[g] = req_dst[g*DSTW +: DSTW];
   end

   // Inputs currently held by a locked output.
   always_comb begin
      owned_s = '0;
      for (int o = 0; o < NPORTS; o++) begin
         owned_s[owner_r[o]] = owned_s[owner_r[o]] | (state_r[o] == LOCKED);
      end
   end

   // A locked output moves a flit only when its owner still targets it and a credit is free.
   always_comb begin
      xfer_s = '0;
      for (int o = 0; o < NPORTS; o++) begin
         xfer_s[o] = (state_r[o] == LOCKED) && req_valid[owner_r[o]] &&
                     (dst_s[owner_r[o]] == DSTW'(o)) && (credit_r[o] != {CRW{1'b0}});
      end
   end

   // Round-robin search for each output, starting just after its last tail owner.
   always_comb begin
      found_s = '0;
      scan_s  = '0;
      for (int o = 0; o < NPORTS; o++) begin
         winner_s[o] = '0;
         for (int k = 1; k <= NPORTS; k++) begin
            scan_s = rr_index(rr_ptr_r[o], k);
            if (!found_s[o] && req_valid[scan_s] && (dst_s[scan_s] == DSTW'(o)) && !owned_s[scan_s]) begin
               found_s[o]  = 1'b1;
               winner_s[o] = scan_s;
            end else begin
               found_s[o] = found_s[o];
            end
         end
      end
   end

   // Error sources: destinations beyond the port range and credit returns into a full counter.
   always_comb begin
      bad_dst_s  = 1'b0;
      overflow_s = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         bad_dst_s  = bad_dst_s | (req_valid[i] && (int'(dst_s[i]) >= NPORTS));
         overflow_s = overflow_s | (credit_ret[i] && !xfer_s[i] && (credit_r[i] == CRW'(CREDITS)));
      end
   end

   // Crossbar and pop strobes, forced low while reset is held.
   always_comb begin
      grant     = '0;
      sel       = '0;
      sel_valid = '0;
      for (int o = 0; o < NPORTS; o++) begin
         if (rst && xfer_s[o]) begin
            grant[owner_r[o]]   = 1'b1;
            sel_valid[o]        = 1'b1;
            sel[o*DSTW +: DSTW] = owner_r[o];
         end else begin
            sel_valid[o] = 1'b0;
         end
      end
   end

   assign dst_err = dst_err_r;

   // Per-output lock FSM, round-robin pointer, credit counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int o = 0; o < NPORTS; o++) begin
            state_r[o]  <= IDLE;
            owner_r[o]  <= '0;
            rr_ptr_r[o] <= DSTW'(NPORTS - 1);
            credit_r[o] <= CRW'(CREDITS);
         end
         dst_err_r <= 1'b0;
      end else begin
         if (bad_dst_s || overflow_s) begin
            dst_err_r <= 1'b1;
         end
         for (int o = 0; o < NPORTS; o++) begin
            case (state_r[o])
               IDLE: begin
                  if (found_s[o] && (credit_r[o] != {CRW{1'b0}})) begin
                     state_r[o] <= LOCKED;
                     owner_r[o] <= winner_s[o];
                  end
               end
               LOCKED: begin
                  if (xfer_s[o] && req_tail[owner_r[o]]) begin
                     state_r[o]  <= IDLE;
                     rr_ptr_r[o] <= owner_r[o];
                  end
               end
               default: begin
                  state_r[o] <= IDLE;
               end
            endcase
            // A simultaneous send and return cancel; a return into a full counter saturates.
            if (xfer_s[o] && !credit_ret[o]) begin
               credit_r[o] <= credit_r[o] - CRW'(1);
            end else if (!xfer_s[o] && credit_ret[o] && (credit_r[o] != CRW'(CREDITS))) begin
               credit_r[o] <= credit_r[o] + CRW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_star_hub_arbiter.sv
// Bench for star_hub_arbiter: directed scenarios and randomized traffic
// compared every cycle against a packet-queue reference model.
module tb_star_hub_arbiter;

   localparam int N  = 10;
   localparam int DW = 4;
   localparam int CR = 4;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_dst;
   logic [N-1:0]    req_tail;
   logic [N-1:0]    credit_ret;
   logic [N-1:0]    grant;
   logic [N*DW-1:0] sel;
   logic [N-1:0]    sel_valid;
   logic            dst_err;

   int checks = 0;
   int errors = 0;

   // Per-input flit queues (head = flit presented to the arbiter).
   int q_dst  [N][$];
   bit q_tail [N][$];

   // Reference state: owner input per output (-1 = free), last tail owner, credits.
   int m_own  [N];
   int m_rr   [N];
   int m_cred [N];
   bit m_err;
   bit m_known = 1'b0;

   logic [N-1:0]    g_hist[$];
   logic [N-1:0]    sv_hist[$];
   logic [N*DW-1:0] sel_hist[$];

   star_hub_arbiter #(.NPORTS(N), .DSTW(DW), .CREDITS(CR), .CRW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_dst    (req_dst),
      .req_tail   (req_tail),
      .credit_ret (credit_ret),
      .grant      (grant),
      .sel        (sel),
      .sel_valid  (sel_valid),
      .dst_err    (dst_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int src, input int dst, input int len);
      for (int f = 0; f < len; f++) begin
         q_dst[src].push_back(dst);
         q_tail[src].push_back(f == len - 1);
      end
   endtask

   task automatic clr_hist();
      g_hist.delete();
      sv_hist.delete();
      sel_hist.delete();
   endtask

   // One clock: present queue heads, check outputs at negedge, then advance the model.
   task automatic cycle(input logic [N-1:0] cret);
      logic [N-1:0]    e_grant;
      logic [N-1:0]    e_sv;
      logic [N*DW-1:0] e_sel;
      bit              xf    [N];
      int              gi    [N];
      bit              owned [N];
      bit              hit;
      int              cand;
      credit_ret = cret;
      for (int i = 0; i < N; i++) begin
         if (q_dst[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_dst[i*DW +: DW] = DW'(q_dst[i][0]);
            req_tail[i]         = q_tail[i][0];
         end else begin
            req_valid[i]        = 1'b0;
            req_dst[i*DW +: DW] = '0;
            req_tail[i]         = 1'b0;
         end
      end
      @(negedge clk);
      e_grant = '0;
      e_sv    = '0;
      e_sel   = '0;
      for (int o = 0; o < N; o++) begin
         xf[o] = 1'b0;
         gi[o] = m_own[o];
         if (rst && m_own[o] >= 0) begin
            if (q_dst[gi[o]].size() > 0 && q_dst[gi[o]][0] == o && m_cred[o] > 0) begin
               xf[o]               = 1'b1;
               e_grant[gi[o]]      = 1'b1;
               e_sv[o]             = 1'b1;
               e_sel[o*DW +: DW]   = DW'(gi[o]);
            end
         end
      end
      chk("grant", grant, e_grant);
      chk("sel_valid", sel_valid, e_sv);
      chk("sel", sel, e_sel);
      if (m_known) chk("dst_err", dst_err, m_err);
      g_hist.push_back(grant);
      sv_hist.push_back(sel_valid);
      sel_hist.push_back(sel);
      @(posedge clk);
      if (!rst) begin
         for (int o = 0; o < N; o++) begin
            m_own[o]  = -1;
            m_rr[o]   = N - 1;
            m_cred[o] = CR;
         end
         m_err   = 1'b0;
         m_known = 1'b1;
      end else begin
         for (int i = 0; i < N; i++) owned[i] = 1'b0;
         for (int o = 0; o < N; o++) if (m_own[o] >= 0) owned[m_own[o]] = 1'b1;
         for (int i = 0; i < N; i++) if (q_dst[i].size() > 0 && q_dst[i][0] >= N) m_err = 1'b1;
         for (int o = 0; o < N; o++) begin
            if (m_own[o] >= 0) begin
               if (xf[o] && q_tail[gi[o]][0]) begin
                  m_rr[o]  = gi[o];
                  m_own[o] = -1;
               end
            end else if (m_cred[o] > 0) begin
               hit = 1'b0;
               for (int k = 1; k <= N; k++) begin
                  cand = (m_rr[o] + k) % N;
                  if (!hit && q_dst[cand].size() > 0 && q_dst[cand][0] == o && !owned[cand]) begin
                     hit      = 1'b1;
                     m_own[o] = cand;
                  end
               end
            end
            if (xf[o] && !cret[o]) m_cred[o]--;
            else if (!xf[o] && cret[o]) begin
               if (m_cred[o] == CR) m_err = 1'b1;
               else m_cred[o]++;
            end
         end
         for (int o = 0; o < N; o++) begin
            if (xf[o]) begin
               void'(q_dst[gi[o]].pop_front());
               void'(q_tail[gi[o]].pop_front());
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         q_dst[i].delete();
         q_tail[i].delete();
      end
      cycle('0);
      cycle('0);
      rst = 1'b1;
   endtask

   initial begin
      logic [N-1:0] cr;
      int           n;
      rst        = 1'b0;
      req_valid  = '0;
      req_dst    = '0;
      req_tail   = '0;
      credit_ret = '0;
      for (int o = 0; o < N; o++) begin
         m_own[o]  = -1;
         m_rr[o]   = N - 1;
         m_cred[o] = CR;
      end
      m_err = 1'b0;

      // Reset state.
      do_reset();
      chk("reset_grant", grant, '0);
      chk("reset_dst_err", dst_err, 1'b0);

      // Round robin among inputs 0, 3, 7 on output 5.
      clr_hist();
      send(0, 5, 1);
      send(3, 5, 1);
      send(7, 5, 1);
      for (int c = 0; c < 7; c++) cycle('0);
      chk("rr_g1", g_hist[1], N'(1) << 0);
      chk("rr_bubble1", g_hist[2], '0);
      chk("rr_g2", g_hist[3], N'(1) << 3);
      chk("rr_bubble2", g_hist[4], '0);
      chk("rr_g3", g_hist[5], N'(1) << 7);
      chk("rr_sel1", sel_hist[1][5*DW +: DW], 4'd0);
      chk("rr_sel2", sel_hist[3][5*DW +: DW], 4'd3);
      chk("rr_sel3", sel_hist[5][5*DW +: DW], 4'd7);

      // Wormhole lock: 3-flit packet from input 2 holds output 1 against input 4.
      do_reset();
      clr_hist();
      send(2, 1, 3);
      send(4, 1, 1);
      for (int c = 0; c < 7; c++) cycle('0);
      for (int k = 1; k <= 3; k++) chk("worm_lock", g_hist[k], N'(1) << 2);
      chk("worm_bubble", g_hist[4], '0);
      chk("worm_next", g_hist[5], N'(1) << 4);

      // Credit stall on output 9, released by two returns.
      do_reset();
      clr_hist();
      send(0, 9, 6);
      for (int c = 0; c < 13; c++) cycle((c == 8 || c == 10) ? (N'(1) << 9) : N'(0));
      chk("cred_g4", g_hist[4], N'(1) << 0);
      chk("cred_stall", g_hist[5], '0);
      chk("cred_stall_sv", sv_hist[6][9], 1'b0);
      chk("cred_g5", g_hist[9], N'(1) << 0);
      chk("cred_gap", g_hist[10], '0);
      chk("cred_g6", g_hist[11], N'(1) << 0);
      chk("cred_idle", g_hist[12], '0);

      // Simultaneous send and return at credit 2, then return into a full counter.
      do_reset();
      clr_hist();
      send(4, 3, 8);
      for (int c = 0; c < 10; c++) cycle((c == 3) ? (N'(1) << 3) : N'(0));
      n = 0;
      for (int k = 0; k < 10; k++) n += int'(g_hist[k][4]);
      chk("simul_cnt", n, 5);
      chk("simul_stall", g_hist[6], '0);
      do_reset();
      cycle(N'(1) << 3);
      chk("ovf_err", dst_err, 1'b1);

      // Parallel outputs plus an out-of-range destination.
      do_reset();
      clr_hist();
      send(1, 2, 1);
      send(5, 6, 1);
      send(8, 0, 1);
      send(9, 12, 1);
      cycle('0);
      chk("bad_dst_err", dst_err, 1'b1);
      for (int c = 0; c < 5; c++) cycle('0);
      chk("parallel", g_hist[1], (N'(1) << 1) | (N'(1) << 5) | (N'(1) << 8));
      n = 0;
      for (int k = 0; k < 6; k++) n += int'(g_hist[k][9]);
      chk("bad_dst_nogrant", n, 0);

      // Reset in the middle of a 4-flit packet.
      do_reset();
      clr_hist();
      send(6, 4, 4);
      cycle('0);
      cycle('0);
      do_reset();
      chk("midrst_grant", g_hist[3], '0);
      chk("midrst_sv", sv_hist[3], '0);
      clr_hist();
      send(0, 4, 4);
      send(6, 4, 1);
      for (int c = 0; c < 7; c++) cycle('0);
      for (int k = 1; k <= 4; k++) chk("midrst_prio", g_hist[k], N'(1) << 0);
      chk("midrst_nocred", g_hist[6], '0);

      // Randomized traffic with one reset midway.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         for (int i = 0; i < N; i++) begin
            if (q_dst[i].size() == 0 && $urandom_range(0, 3) == 0)
               send(i, int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)));
         end
         for (int o = 0; o < N; o++) cr[o] = ($urandom_range(0, 3) == 0);
         cycle(cr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
